fir_coef_loader: RTL
====================

// Module: fir_coef_loader
// PURPOSE
//  Host-side configuration end of the 33-tap FIR filter's coefficient interface.
//  Host writes coefficients into a shadow bank through a simple write/readback port.
//  On commit, the block waits for a gap in the sample stream and copies shadow to active.
//  It then pulses the filter's active-low reset so the filter re-latches coef_0..coef_32.
// PARAMETERS
//  NUM_TAPS        33    coefficient count; active outputs coef_0..coef_32
//  COEF_W          32    coefficient width, signed Q15.16
//  ADDR_W          6     host address width
//  QUIET_CYCLES    8     consecutive stream_valid=0 cycles required before reload
//  TIMEOUT_CYCLES  1024  max QUIESCE cycles before forced reload
//  RELOAD_CYCLES   4     cycles fir_reset_n is held low (>=2)
// PORTS
//  clk           in   1       system clock
//  reset         in   1       synchronous, active-high reset
//  wr_en         in   1       host write strobe
//  wr_addr       in   ADDR_W  shadow index 0..NUM_TAPS-1
//  wr_data       in   COEF_W  coefficient value
//  rd_addr       in   ADDR_W  shadow readback index
//  rd_data       out  COEF_W  shadow[rd_addr], 1-cycle latency
//  commit        in   1       request shadow->active transfer (single-cycle pulse)
//  stream_valid  in   1       filter input valid, monitored for idle gaps
//  coef_0..coef_32 out COEF_W each, active bank; registered; drive filter coef_k
//  fir_reset_n   out  1       filter reset, active low, registered
//  busy          out  1       high in any state other than IDLE
//  done          out  1       1-cycle pulse when fir_reset_n returns high
//  forced        out  1       sticky: a reload was forced by timeout
//  err_addr      out  1       sticky: write with wr_addr >= NUM_TAPS
// BEHAVIOUR
//  - Reset values:
//    - shadow[0] = active[0] = 32'h0001_0000 (unity, identity filter); all other taps 0.
//    - fir_reset_n=0 while reset is high; it goes to 1 on the first cycle after reset falls.
//    - rd_data=0, busy=0, done=0, forced=0, err_addr=0; state = IDLE.
//  - Writes:
//    - Accepted in every state; shadow[wr_addr] <= wr_data.
//    - wr_addr >= NUM_TAPS: no write; err_addr <= 1.
//  - Readback: rd_data <= shadow[rd_addr] each cycle; returns 0 when rd_addr >= NUM_TAPS.
//  - FSM IDLE -> QUIESCE -> LOAD -> IDLE:
//    - IDLE: commit=1 -> QUIESCE; quiet_cnt and timeout_cnt are cleared.
//    - QUIESCE:
//      - stream_valid=1 clears quiet_cnt; otherwise quiet_cnt increments. timeout_cnt increments every cycle.
//      - When quiet_cnt hits QUIET_CYCLES -> LOAD.
//      - Else, when timeout_cnt hits TIMEOUT_CYCLES -> LOAD and forced <= 1.
//    - LOAD:
//      - On the entry cycle, active <= shadow (all taps in one cycle) and fir_reset_n <= 0.
//      - Stays for RELOAD_CYCLES cycles, then fir_reset_n <= 1, done <= 1, next state IDLE.
//  - Latency, stream idle, defaults: commit sampled at cycle T.
//    - fir_reset_n is low T+9..T+12, coef_k is updated from T+9, done=1 at T+13.
//  - A commit while busy sets a pending flag, and duplicate commits merge into it.
//    - On return to IDLE, pending re-enters QUIESCE directly and clears the flag.
//  - Write on the LOAD entry cycle: active takes the pre-write shadow value; the write lands in shadow only.
//  - Reset mid-operation: everything returns to reset values at once; pending is discarded.
//  - coef_k outputs change only on the LOAD entry cycle or on reset; never at any other time.
// STRUCTURE
//  - Package fir_cfg_pkg holds:
//    - constants NUM_TAPS, COEF_W, Q_FRAC=16, UNITY_COEF=32'h0001_0000;
//    - the state encoding (IDLE, QUIESCE, LOAD).
//  - Sub-module fir_coef_bank holds:
//    - the shadow and active arrays, write decode and readback mux;
//    - the copy strobe, and the active bank flattened to the coef outputs.
//  - The top level holds the FSM, counters, pending flag and status flags.
// TESTING
//  1. Reset:
//     - Release reset, then read rd_addr=0..32 -> 0x00010000, then 0 x32.
//     - coef_0=0x00010000 and fir_reset_n=1 on the first cycle after release.
//  2. Write and commit, stream idle:
//     - Write tap k = k+1 for all taps, then commit at T.
//     - fir_reset_n low T+9..T+12; coef_5=6 from T+9; done at T+13; forced stays 0.
//  3. Busy stream:
//     - stream_valid=1 for 20 cycles after commit, then 0.
//     - LOAD is entered 8 quiet cycles after the gap starts.
//  4. Timeout:
//     - stream_valid held 1 after commit.
//     - LOAD entered at timeout_cnt=1024; forced=1 and stays set until reset.
//  5. Pending and overlap:
//     - Second commit during LOAD -> a second QUIESCE/LOAD sequence follows, with exactly 2 done pulses.
//     - Write to tap 3 on the LOAD entry cycle -> coef_3 keeps its old value; rd_data shows the new one.
//  6. Errors and reset mid-op:
//     - Write to addr 40 -> err_addr=1, no tap changes.
//     - Assert reset in QUIESCE -> busy=0 and coef_0=0x00010000 on the next cycle.

Source files
------------

// File: rtl/fir_cfg_pkg.sv
// Shared constants and FSM state encoding for the FIR coefficient loader.
package fir_cfg_pkg;

   localparam int unsigned NUM_TAPS = 33;
   localparam int unsigned COEF_W = 32;
   localparam int unsigned Q_FRAC = 16;
   localparam logic [COEF_W-1:0] UNITY_COEF = 32'h0001_0000;

   typedef enum logic [1:0] {
      IDLE,
      QUIESCE,
      LOAD
   } state_t;

endpackage

// File: rtl/fir_coef_bank.sv
// Shadow/active coefficient storage: host write decode, readback mux and bulk shadow->active copy.
module fir_coef_bank
   import fir_cfg_pkg::*;
#(
   parameter int unsigned ADDR_W = 6
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         wr_en,
   input  logic [ADDR_W-1:0]            wr_addr,
   input  logic [COEF_W-1:0]            wr_data,
   input  logic [ADDR_W-1:0]            rd_addr,
   input  logic                         copy,
   output logic [COEF_W-1:0]            rd_data,
   output logic [NUM_TAPS*COEF_W-1:0]   active_flat,
   output logic                         wr_err
);

   localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_TAPS - 1);

   logic [COEF_W-1:0] shadow [NUM_TAPS];
   logic [COEF_W-1:0] active [NUM_TAPS];
   logic              wr_ok;
   logic              rd_ok;

   assign wr_ok  = (wr_addr <= LAST_ADDR);
   assign rd_ok  = (rd_addr <= LAST_ADDR);
   assign wr_err = wr_en && !wr_ok;

   // A write on the copy edge lands in shadow only; active takes the pre-write value.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < NUM_TAPS; i++) begin
            shadow[i] <= '0;
            active[i] <= '0;
         end
         shadow[0] <= UNITY_COEF;
         active[0] <= UNITY_COEF;
         rd_data   <= '0;
      end else begin
         if (wr_en && wr_ok) begin
            shadow[wr_addr] <= wr_data;
         end
         if (copy) begin
            active <= shadow;
         end
         rd_data <= rd_ok ? shadow[rd_addr] : '0;
      end
   end

   always_comb begin
      active_flat = '0;
      for (int unsigned i = 0; i < NUM_TAPS; i++) begin
         active_flat[i*COEF_W +: COEF_W] = active[i];
      end
   end

endmodule

// File: rtl/fir_coef_loader.sv
// Coefficient loader: waits for a quiet gap in the sample stream, swaps shadow into active,
// then holds the filter in reset so it re-latches coef_0..coef_32.
module fir_coef_loader
   import fir_cfg_pkg::*;
#(
   parameter int unsigned ADDR_W         = 6,
   parameter int unsigned QUIET_CYCLES   = 8,
   parameter int unsigned TIMEOUT_CYCLES = 1024,
   parameter int unsigned RELOAD_CYCLES  = 4
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [COEF_W-1:0] wr_data,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [COEF_W-1:0] rd_data,
   input  logic              commit,
   input  logic              stream_valid,
   output logic [COEF_W-1:0] coef_0,
   output logic [COEF_W-1:0] coef_1,
   output logic [COEF_W-1:0] coef_2,
   output logic [COEF_W-1:0] coef_3,
   output logic [COEF_W-1:0] coef_4,
   output logic [COEF_W-1:0] coef_5,
   output logic [COEF_W-1:0] coef_6,
   output logic [COEF_W-1:0] coef_7,
   output logic [COEF_W-1:0] coef_8,
   output logic [COEF_W-1:0] coef_9,
   output logic [COEF_W-1:0] coef_10,
   output logic [COEF_W-1:0] coef_11,
   output logic [COEF_W-1:0] coef_12,
   output logic [COEF_W-1:0] coef_13,
   output logic [COEF_W-1:0] coef_14,
   output logic [COEF_W-1:0] coef_15,
   output logic [COEF_W-1:0] coef_16,
   output logic [COEF_W-1:0] coef_17,
   output logic [COEF_W-1:0] coef_18,
   output logic [COEF_W-1:0] coef_19,
   output logic [COEF_W-1:0] coef_20,
   output logic [COEF_W-1:0] coef_21,
   output logic [COEF_W-1:0] coef_22,
   output logic [COEF_W-1:0] coef_23,
   output logic [COEF_W-1:0] coef_24,
   output logic [COEF_W-1:0] coef_25,
   output logic [COEF_W-1:0] coef_26,
   output logic [COEF_W-1:0] coef_27,
   output logic [COEF_W-1:0] coef_28,
   output logic [COEF_W-1:0] coef_29,
   output logic [COEF_W-1:0] coef_30,
   output logic [COEF_W-1:0] coef_31,
   output logic [COEF_W-1:0] coef_32,
   output logic              fir_reset_n,
   output logic              busy,
   output logic              done,
   output logic              forced,
   output logic              err_addr
);

   localparam int unsigned QW = $clog2(QUIET_CYCLES + 1);
   localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam int unsigned RW = $clog2(RELOAD_CYCLES);

   state_t                     state;
   logic [QW-1:0]              quiet_cnt;
   logic [TW-1:0]              timeout_cnt;
   logic [RW-1:0]              reload_cnt;
   logic                       pending;
   logic                       quiet_hit;
   logic                       timeout_hit;
   logic                       copy;
   logic                       wr_err;
   logic [NUM_TAPS*COEF_W-1:0] active_flat;

   assign quiet_hit   = (quiet_cnt == QW'(QUIET_CYCLES));
   assign timeout_hit = (timeout_cnt == TW'(TIMEOUT_CYCLES));
   // The copy fires on the edge that enters LOAD, so coef and fir_reset_n change together.
   assign copy        = (state == QUIESCE) && (quiet_hit || timeout_hit);

   fir_coef_bank #(
      .ADDR_W (ADDR_W)
   ) u_bank (
      .clk         (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_addr     (wr_addr),
      .wr_data     (wr_data),
      .rd_addr     (rd_addr),
      .copy        (copy),
      .rd_data     (rd_data),
      .active_flat (active_flat),
      .wr_err      (wr_err)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= IDLE;
         quiet_cnt   <= '0;
         timeout_cnt <= '0;
         reload_cnt  <= '0;
         pending     <= 1'b0;
         fir_reset_n <= 1'b0;
         busy        <= 1'b0;
         done        <= 1'b0;
         forced      <= 1'b0;
         err_addr    <= 1'b0;
      end else begin
         done <= 1'b0;
         if (wr_err) begin
            err_addr <= 1'b1;
         end
         case (state)
            IDLE: begin
               fir_reset_n <= 1'b1;
               if (commit || pending) begin
                  state       <= QUIESCE;
                  quiet_cnt   <= '0;
                  timeout_cnt <= '0;
                  pending     <= 1'b0;
                  busy        <= 1'b1;
               end
            end
            QUIESCE: begin
               if (commit) begin
                  pending <= 1'b1;
               end
               timeout_cnt <= timeout_cnt + 1'b1;
               quiet_cnt   <= stream_valid ? '0 : quiet_cnt + 1'b1;
               if (quiet_hit || timeout_hit) begin
                  state       <= LOAD;
                  fir_reset_n <= 1'b0;
                  reload_cnt  <= '0;
                  if (!quiet_hit) begin
                     forced <= 1'b1;
                  end
               end
            end
            LOAD: begin
               if (commit) begin
                  pending <= 1'b1;
               end
               if (reload_cnt == RW'(RELOAD_CYCLES - 1)) begin
                  state       <= IDLE;
                  fir_reset_n <= 1'b1;
                  done        <= 1'b1;
                  busy        <= 1'b0;
               end else begin
                  reload_cnt <= reload_cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

   assign coef_0  = active_flat[0*COEF_W  +: COEF_W];
   assign coef_1  = active_flat[1*COEF_W  +: COEF_W];
   assign coef_2  = active_flat[2*COEF_W  +: COEF_W];
   assign coef_3  = active_flat[3*COEF_W  +: COEF_W];
   assign coef_4  = active_flat[4*COEF_W  +: COEF_W];
   assign coef_5  = active_flat[5*COEF_W  +: COEF_W];
   assign coef_6  = active_flat[6*COEF_W  +: COEF_W];
   assign coef_7  = active_flat[7*COEF_W  +: COEF_W];
   assign coef_8  = active_flat[8*COEF_W  +: COEF_W];
   assign coef_9  = active_flat[9*COEF_W  +: COEF_W];
   assign coef_10 = active_flat[10*COEF_W +: COEF_W];
   assign coef_11 = active_flat[11*COEF_W +: COEF_W];
   assign coef_12 = active_flat[12*COEF_W +: COEF_W];
   assign coef_13 = active_flat[13*COEF_W +: COEF_W];
   assign coef_14 = active_flat[14*COEF_W +: COEF_W];
   assign coef_15 = active_flat[15*COEF_W +: COEF_W];
   assign coef_16 = active_flat[16*COEF_W +: COEF_W];
   assign coef_17 = active_flat[17*COEF_W +: COEF_W];
   assign coef_18 = active_flat[18*COEF_W +: COEF_W];
   assign coef_19 = active_flat[19*COEF_W +: COEF_W];
   assign coef_20 = active_flat[20*COEF_W +: COEF_W];
   assign coef_21 = active_flat[21*COEF_W +: COEF_W];
   assign coef_22 = active_flat[22*COEF_W +: COEF_W];
   assign coef_23 = active_flat[23*COEF_W +: COEF_W];
   assign coef_24 = active_flat[24*COEF_W +: COEF_W];
   assign coef_25 = active_flat[25*COEF_W +: COEF_W];
   assign coef_26 = active_flat[26*COEF_W +: COEF_W];
   assign coef_27 = active_flat[27*COEF_W +: COEF_W];
   assign coef_28 = active_flat[28*COEF_W +: COEF_W];
   assign coef_29 = active_flat[29*COEF_W +: COEF_W];
   assign coef_30 = active_flat[30*COEF_W +: COEF_W];
   assign coef_31 = active_flat[31*COEF_W +: COEF_W];
   assign coef_32 = active_flat[32*COEF_W +: COEF_W];

endmodule
